// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl bundle: execute-side input handshake, data-memory bus and writeback output.
// master = controller view, slave = environment view (execute, memory, writeback).
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // execute -> controller
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;

  // controller -> memory request
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_wen;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [3:0]        mem_req_wmask;

  // memory -> controller response
  logic              mem_rsp_valid;
  logic              mem_rsp_ready;
  logic [DATA_W-1:0] mem_rsp_rdata;
  logic              mem_rsp_err;

  // controller -> writeback
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rdata;
  logic              out_err;

  modport master (
    input  in_valid,
    output in_ready,
    input  in_inst,
    input  in_addr,
    input  in_wdata,
    output mem_req_valid,
    input  mem_req_ready,
    output mem_req_wen,
    output mem_req_addr,
    output mem_req_wdata,
    output mem_req_wmask,
    input  mem_rsp_valid,
    output mem_rsp_ready,
    input  mem_rsp_rdata,
    input  mem_rsp_err,
    output out_valid,
    input  out_ready,
    output out_rdata,
    output out_err
  );

  modport slave (
    output in_valid,
    input  in_ready,
    output in_inst,
    output in_addr,
    output in_wdata,
    input  mem_req_valid,
    output mem_req_ready,
    input  mem_req_wen,
    input  mem_req_addr,
    input  mem_req_wdata,
    input  mem_req_wmask,
    output mem_rsp_valid,
    input  mem_rsp_ready,
    output mem_rsp_rdata,
    output mem_rsp_err,
    input  out_valid,
    output out_ready,
    input  out_rdata,
    input  out_err
  );

endinterface

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store controller: one instruction at a time, one bus transaction max.
// Ports: clk, rst (sync, active-high), bus (lsu_ctrl_if.master: in_*, mem_req_*, mem_rsp_*, out_*).
module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic        clk,
  input logic        rst,
  lsu_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_t state;

  // registered outputs
  logic              in_ready_q;
  logic              req_valid_q;
  logic              req_wen_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [3:0]        req_wmask_q;
  logic              rsp_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_rdata_q;
  logic              out_err_q;

  // per-instruction context
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              store_q;

  // incoming instruction decode
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [1:0]        offset;
  logic              is_load;
  logic              is_store;
  logic              f3_ok;
  logic              aligned;
  logic [3:0]        base_mask;
  logic              go_mem;
  logic              bad_mem;
  logic [3:0]        st_mask;
  logic [DATA_W-1:0] st_data;

  // load return path
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ld_data;

  logic              unused;

  assign opcode = bus.in_inst[6:0];
  assign funct3 = bus.in_inst[14:12];
  assign offset = bus.in_addr[1:0];

  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);

  assign unused = ^{bus.in_inst[31:15], bus.in_inst[11:7]};

  always_comb begin
    f3_ok = 1'b0;
    unique case (1'b1)
      is_load:  f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                        (funct3 == 3'b010) || (funct3 == 3'b100) ||
                        (funct3 == 3'b101);
      is_store: f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                        (funct3 == 3'b010);
      default:  f3_ok = 1'b0;
    endcase
  end

  // funct3[1:0] carries the access size for both loads and stores
  always_comb begin
    aligned   = 1'b0;
    base_mask = 4'b0000;
    case (funct3[1:0])
      2'b00: begin
        aligned   = 1'b1;
        base_mask = 4'b0001;
      end
      2'b01: begin
        aligned   = ~offset[0];
        base_mask = 4'b0011;
      end
      2'b10: begin
        aligned   = (offset == 2'b00);
        base_mask = 4'b1111;
      end
      default: begin
        aligned   = 1'b0;
        base_mask = 4'b0000;
      end
    endcase
  end

  assign go_mem  = (is_load || is_store) && f3_ok && aligned;
  assign bad_mem = (is_load || is_store) && !(f3_ok && aligned);

  assign st_mask = base_mask << offset;
  assign st_data = bus.in_wdata << {offset, 3'b000};

  assign shifted = bus.mem_rsp_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (f3_q)
      3'b000:  ld_data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      3'b101:  ld_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      req_valid_q <= 1'b0;
      req_wen_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= 4'b0000;
      rsp_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_rdata_q <= '0;
      out_err_q   <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      store_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            f3_q       <= funct3;
            off_q      <= offset;
            store_q    <= is_store;
            if (go_mem) begin
              state       <= REQ;
              req_valid_q <= 1'b1;
              req_wen_q   <= is_store;
              req_addr_q  <= {bus.in_addr[ADDR_W-1:2], 2'b00};
              req_wdata_q <= is_store ? st_data : '0;
              req_wmask_q <= is_store ? st_mask : 4'b0000;
            end else begin
              // non-memory or rejected access: answer without the bus
              state       <= RESP;
              out_valid_q <= 1'b1;
              out_rdata_q <= '0;
              out_err_q   <= bad_mem;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            state       <= WAIT;
            req_valid_q <= 1'b0;
            req_wen_q   <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wmask_q <= 4'b0000;
            rsp_ready_q <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            state       <= RESP;
            rsp_ready_q <= 1'b0;
            out_valid_q <= 1'b1;
            out_err_q   <= bus.mem_rsp_err;
            if (bus.mem_rsp_err || store_q)
              out_rdata_q <= '0;
            else
              out_rdata_q <= ld_data;
          end
        end
        RESP: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_rdata_q <= '0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_wen   = req_wen_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_req_wmask = req_wmask_q;
  assign bus.mem_rsp_ready = rsp_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_rdata     = out_rdata_q;
  assign bus.out_err       = out_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed vector table plus stall, backpressure and reset sequences.
// Drives inputs and samples outputs on the falling clock edge.
module tb_lsu_ctrl;

  logic clk;
  logic rst;

  lsu_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int hs_cnt;

  always @(posedge clk)
    if (bus.mem_req_valid && bus.mem_req_ready) hs_cnt++;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rsp_err;
    logic        memop;
    logic        wen;
    logic [31:0] req_addr;
    logic [3:0]  wmask;
    logic [31:0] req_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  function automatic logic [31:0] mk(input logic [2:0] f3,
                                     input logic [6:0] op);
    return {17'd0, f3, 5'd0, op};
  endfunction

  function automatic vec_t mkv(
    input string nm, input logic [31:0] inst, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [31:0] rdata, input logic rerr,
    input logic memop, input logic wen, input logic [31:0] raddr,
    input logic [3:0] wmask, input logic [31:0] rwdata,
    input logic [31:0] erdata, input logic eerr);
    vec_t v;
    v.name = nm; v.inst = inst; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.rsp_err = rerr; v.memop = memop; v.wen = wen;
    v.req_addr = raddr; v.wmask = wmask; v.req_wdata = rwdata;
    v.exp_rdata = erdata; v.exp_err = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus.in_valid      = 1'b0;
    bus.in_inst       = '0;
    bus.in_addr       = '0;
    bus.in_wdata      = '0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = '0;
    bus.mem_rsp_err   = 1'b0;
    bus.out_ready     = 1'b1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_addr  = addr;
    bus.in_wdata = wdata;
  endtask

  // zero-wait bus, writeback always ready; cycle 0 = accept
  task automatic run_vec(input vec_t v);
    chk({v.name, " in_ready c0"}, 32'(bus.in_ready), 32'd1);
    issue(v.inst, v.addr, v.wdata);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({v.name, " in_ready c1"}, 32'(bus.in_ready), 32'd0);
    if (v.memop) begin
      chk({v.name, " req_valid c1"}, 32'(bus.mem_req_valid), 32'd1);
      chk({v.name, " req_wen"}, 32'(bus.mem_req_wen), 32'(v.wen));
      chk({v.name, " req_addr"}, bus.mem_req_addr, v.req_addr);
      chk({v.name, " req_wmask"}, 32'(bus.mem_req_wmask), 32'(v.wmask));
      chk({v.name, " req_wdata"}, bus.mem_req_wdata, v.req_wdata);
      chk({v.name, " out_valid c1"}, 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk({v.name, " req_valid c2"}, 32'(bus.mem_req_valid), 32'd0);
      chk({v.name, " rsp_ready c2"}, 32'(bus.mem_rsp_ready), 32'd1);
      chk({v.name, " out_valid c2"}, 32'(bus.out_valid), 32'd0);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = v.rdata;
      bus.mem_rsp_err   = v.rsp_err;
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_err   = 1'b0;
      chk({v.name, " rsp_ready c3"}, 32'(bus.mem_rsp_ready), 32'd0);
    end else begin
      chk({v.name, " no req"}, 32'(bus.mem_req_valid), 32'd0);
    end
    chk({v.name, " out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({v.name, " out_rdata"}, bus.out_rdata, v.exp_rdata);
    chk({v.name, " out_err"}, 32'(bus.out_err), 32'(v.exp_err));
    @(negedge clk);
    chk({v.name, " out_valid done"}, 32'(bus.out_valid), 32'd0);
    chk({v.name, " in_ready done"}, 32'(bus.in_ready), 32'd1);
  endtask

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  vec_t vt[14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mkv("lb", mk(3'b000, LD), 32'h8000_0003, 0, 32'h8012_3456, 0,
                 1, 0, 32'h8000_0000, 4'b0000, 0, 32'hFFFF_FF80, 0);
    vt[1]  = mkv("lhu", mk(3'b101, LD), 32'h8000_0002, 0, 32'hBEEF_1234, 0,
                 1, 0, 32'h8000_0000, 4'b0000, 0, 32'h0000_BEEF, 0);
    vt[2]  = mkv("lh", mk(3'b001, LD), 32'h8000_0002, 0, 32'hBEEF_1234, 0,
                 1, 0, 32'h8000_0000, 4'b0000, 0, 32'hFFFF_BEEF, 0);
    vt[3]  = mkv("sh", mk(3'b001, ST), 32'h8000_0102, 32'h1234_ABCD,
                 32'hDEAD_BEEF, 0, 1, 1, 32'h8000_0100, 4'b1100,
                 32'hABCD_0000, 0, 0);
    vt[4]  = mkv("lw misal", mk(3'b010, LD), 32'h8000_0002, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 1);
    vt[5]  = mkv("ld f3 011", mk(3'b011, LD), 32'h8000_0000, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 1);
    vt[6]  = mkv("addi", 32'h0010_0093, 32'h8000_0003, 32'hFFFF_FFFF, 0, 0,
                 0, 0, 0, 0, 0, 0, 0);
    vt[7]  = mkv("lw buserr", mk(3'b010, LD), 32'h8000_0010, 0,
                 32'hCAFE_F00D, 1, 1, 0, 32'h8000_0010, 4'b0000, 0, 0, 1);
    vt[8]  = mkv("sb", mk(3'b000, ST), 32'h8000_0001, 32'h0000_00A5, 0, 0,
                 1, 1, 32'h8000_0000, 4'b0010, 32'h0000_A500, 0, 0);
    vt[9]  = mkv("lbu", mk(3'b100, LD), 32'h8000_0001, 0, 32'h1122_F344, 0,
                 1, 0, 32'h8000_0000, 4'b0000, 0, 32'h0000_00F3, 0);
    vt[10] = mkv("sw", mk(3'b010, ST), 32'h8000_0000, 32'h0102_0304, 0, 0,
                 1, 1, 32'h8000_0000, 4'b1111, 32'h0102_0304, 0, 0);
    vt[11] = mkv("sh misal", mk(3'b001, ST), 32'h8000_0001, 32'h1111_2222,
                 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[12] = mkv("st f3 011", mk(3'b011, ST), 32'h8000_0000, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 1);
    vt[13] = mkv("lb pos", mk(3'b000, LD), 32'h8000_0006, 0, 32'h007F_0000, 0,
                 1, 0, 32'h8000_0004, 4'b0000, 0, 32'h0000_007F, 0);

    n_chk  = 0;
    n_fail = 0;
    hs_cnt = 0;
    idle_bus();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst rsp_ready", 32'(bus.mem_rsp_ready), 32'd0);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_rdata", bus.out_rdata, 32'd0);
    chk("rst out_err", 32'(bus.out_err), 32'd0);
    chk("rst wmask", 32'(bus.mem_req_wmask), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_vec(vt[i]);

    // sw with request stalled 3 cycles
    begin
      int hs0;
      hs0 = hs_cnt;
      bus.mem_req_ready = 1'b0;
      issue(mk(3'b010, ST), 32'h8000_0204, 32'h55AA_33CC);
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("stall req_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("stall req_addr", bus.mem_req_addr, 32'h8000_0204);
        chk("stall req_wen", 32'(bus.mem_req_wen), 32'd1);
        chk("stall wmask", 32'(bus.mem_req_wmask), 32'hF);
        chk("stall wdata", bus.mem_req_wdata, 32'h55AA_33CC);
        chk("stall in_ready", 32'(bus.in_ready), 32'd0);
        if (c == 4) bus.mem_req_ready = 1'b1;
      end
      @(negedge clk);
      chk("stall req done", 32'(bus.mem_req_valid), 32'd0);
      chk("stall rsp_ready", 32'(bus.mem_rsp_ready), 32'd1);
      chk("stall in_ready w", 32'(bus.in_ready), 32'd0);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'h7777_7777;
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      chk("stall out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall out_rdata", bus.out_rdata, 32'd0);
      chk("stall out_err", 32'(bus.out_err), 32'd0);
      chk("stall handshakes", 32'(hs_cnt - hs0), 32'd1);
      @(negedge clk);
      chk("stall idle", 32'(bus.in_ready), 32'd1);
    end

    // writeback backpressure for 2 cycles
    issue(mk(3'b010, LD), 32'h8000_0040, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'h1357_9BDF;
    bus.out_ready     = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = 32'h0;
      chk("bp out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp out_rdata", bus.out_rdata, 32'h1357_9BDF);
      chk("bp in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp released", 32'(bus.out_valid), 32'd0);
    chk("bp idle", 32'(bus.in_ready), 32'd1);

    // reset while waiting for the response, then a stale response
    issue(mk(3'b010, LD), 32'h8000_0080, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rw in WAIT", 32'(bus.mem_rsp_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rw in_ready", 32'(bus.in_ready), 32'd1);
    chk("rw req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rw rsp_ready", 32'(bus.mem_rsp_ready), 32'd0);
    chk("rw out_valid", 32'(bus.out_valid), 32'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("rw late out_valid", 32'(bus.out_valid), 32'd0);
    chk("rw late out_rdata", bus.out_rdata, 32'd0);
    chk("rw late in_ready", 32'(bus.in_ready), 32'd1);

    // the controller still works after the abandoned transaction
    run_vec(vt[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multi-cycle load/store controller between the execute stage and the data-memory bus.
- Accepts one instruction at a time from execute over a valid/ready handshake.
- For loads and stores, performs byte-lane alignment, write-mask generation and a single bus transaction; for loads, also does sign/zero extension of the returned data.
- Hands the result to writeback over a second valid/ready handshake. Non-memory instructions pass through with no bus activity.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32 (four byte lanes).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute presents an instruction.
- in_ready  out  1  controller can accept; high only in IDLE.
- in_inst  in  32  instruction word; opcode = [6:0], funct3 = [14:12].
- in_addr  in  ADDR_W  effective address (byte).
- in_wdata  in  DATA_W  store data, unshifted (rs2).
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts request.
- mem_req_wen  out  1  1 = write, 0 = read.
- mem_req_addr  out  ADDR_W  word-aligned address: in_addr with [1:0] forced to 0.
- mem_req_wdata  out  DATA_W  store data shifted to its byte lane.
- mem_req_wmask  out  4  byte-enable mask, shifted.
- mem_rsp_valid  in  1  bus response valid; reads carry data, writes are acks.
- mem_rsp_ready  out  1  high only in WAIT.
- mem_rsp_rdata  in  DATA_W  raw 32-bit word.
- mem_rsp_err  in  1  bus error flag.
- out_valid  out  1  result valid to writeback.
- out_ready  in  1  writeback accepts.
- out_rdata  out  DATA_W  extended load data; 0 for stores and non-memory instructions.
- out_err  out  1  misaligned access, unsupported funct3, or bus error.

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Reset value is IDLE.
- Reset values: all outputs 0 except in_ready = 1. Internal registers are cleared.
- IDLE:
  - in_ready = 1. On in_valid, latch inst, addr, wdata and offset = addr[1:0].
  - Load (opcode 0000011) or store (opcode 0100011) with a legal, aligned access -> REQ.
  - Any other opcode -> RESP with rdata = 0, err = 0.
  - Illegal or misaligned access -> RESP with err = 1, rdata = 0, and no bus request issued.
- Legal funct3:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other funct3 for a load or store opcode is illegal.
- Alignment: halfword requires offset[0] = 0; word requires offset = 0; byte is always aligned.
- REQ:
  - mem_req_valid = 1 with addr, wen, wdata and wmask held stable until mem_req_ready.
  - On the valid && ready cycle -> WAIT.
- Store encoding:
  - wmask = base << offset, with base sb = 0001, sh = 0011, sw = 1111.
  - wdata = in_wdata << (offset*8).
  - Loads drive wmask = 0000 and wdata = 0.
- WAIT:
  - mem_rsp_ready = 1. On mem_rsp_valid, register the result and go to RESP.
  - Load result: shifted = rdata >> (offset*8), then
    - lb: sign-extend [7:0]
    - lbu: zero-extend [7:0]
    - lh: sign-extend [15:0]
    - lhu: zero-extend [15:0]
    - lw: full word.
  - err = mem_rsp_err. When err = 1, rdata = 0.
- RESP:
  - out_valid = 1; out_rdata and out_err are registered and held stable until out_ready.
  - On out_valid && out_ready -> IDLE.
  - No bypass: the next instruction is accepted no earlier than the cycle after the handshake.
- Latency with a zero-wait bus (req_ready = 1, rsp one cycle after request) and out_ready = 1:
  - Accept at cycle 0, request at cycle 1, response at cycle 2, out_valid at cycle 3.
  - Non-memory or error instruction: out_valid at cycle 1.
- At most one outstanding bus transaction. mem_rsp_valid outside WAIT is ignored.
- rst asserted in any state, including REQ and WAIT:
  - Next cycle is IDLE and all valids are 0.
  - An in-flight bus transaction is abandoned; the bus side must tolerate the dropped request.

Test Plan:
- lb at 0x8000_0003, bus returns 0x8012_3456 -> req addr 0x8000_0000, wmask 0000; out_rdata 0xFFFF_FF80, out_err 0; out_valid 3 cycles after accept.
- lhu at 0x8000_0002, bus returns 0xBEEF_1234 -> out_rdata 0x0000_BEEF. Same access as lh -> 0xFFFF_BEEF.
- sh at 0x8000_0102, wdata 0x1234_ABCD -> mem_req_wen 1, addr 0x8000_0100, wmask 1100, wdata 0xABCD_0000; ack gives out_rdata 0, out_err 0.
- mem_req_ready held low 3 cycles during sw -> mem_req_valid and all request fields stable for 4 cycles; exactly one handshake; in_ready stays 0 throughout.
- lw at 0x8000_0002 -> no mem_req_valid at any cycle; out_valid at cycle 1 with out_err 1, out_rdata 0. Load with funct3 011 gives the same response.
- Cases for the out_ready path, bus errors and reset:
  - out_ready low 2 cycles -> out_valid and out_rdata held.
  - mem_rsp_err 1 -> out_err 1, out_rdata 0.
  - rst pulsed in WAIT -> next cycle IDLE, in_ready 1, all valids 0, and a late mem_rsp_valid produces no output.
